// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, debug view,
// writeback selector codes and memory latency limits.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_DONE    = 3'd4
  } lsu_state_e;

  // Writeback selector codes shared by controller, selector and this block.
  localparam logic [1:0] WB_SEL_ALU   = 2'b00;
  localparam logic [1:0] WB_SEL_SHIFT = 2'b01;
  localparam logic [1:0] WB_SEL_REG   = 2'b10;
  localparam logic [1:0] WB_SEL_MEM   = 2'b11;

  localparam int MEM_LATENCY_MIN = 1;
  localparam int MEM_LATENCY_MAX = 4;

  typedef struct packed {
    lsu_state_e  state;
    logic [2:0]  wait_cnt;
  } lsu_dbg_t;

  function automatic bit latency_ok(input int lat);
    return (lat >= MEM_LATENCY_MIN) && (lat <= MEM_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Controller/memory-facing bundle of the load/store unit.
// Handshake: start is a level sampled only while the unit is idle or finishing
// (busy=0); the unit answers with busy for the access and a one-cycle done.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);

  logic                  start;
  logic                  isStore;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] storeData;
  logic [DATA_WIDTH-1:0] memRdata;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWdata;
  logic                  memWe;
  logic                  memRe;
  logic [DATA_WIDTH-1:0] loadData;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, isStore, addr, storeData, memRdata,
    output memAddr, memWdata, memWe, memRe, loadData, busy, done
  );

  modport master (
    output start, isStore, addr, storeData, memRdata,
    input  memAddr, memWdata, memWe, memRe, loadData, busy, done
  );

endinterface

// File: rtl/load_store_unit.sv
// Single-word load/store sequencer between the datapath and a synchronous
// data-memory RAM with a fixed read latency of MEM_LATENCY cycles.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  load_store_unit_if.slave       bus,
  output lsu_dbg_t               dbg
);

  if (!latency_ok(MEM_LATENCY)) begin : g_bad_latency
    $error("load_store_unit: MEM_LATENCY must be in 1..4");
  end

  localparam logic [2:0] LAST_WAIT = 3'(MEM_LATENCY - 1);

  lsu_state_e state;
  logic [2:0] wait_cnt;

  always_comb begin
    dbg          = '0;
    dbg.state    = state;
    dbg.wait_cnt = wait_cnt;
  end

  // Every output is a register; the accept edge loads the first-cycle values
  // directly so WR/RD_REQ see the strobe and address with no extra stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= 3'd0;
      bus.memAddr  <= {ADDR_WIDTH{1'b0}};
      bus.memWdata <= {DATA_WIDTH{1'b0}};
      bus.loadData <= {DATA_WIDTH{1'b0}};
      bus.memWe    <= 1'b0;
      bus.memRe    <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.memWe <= 1'b0;
      bus.memRe <= 1'b0;
      bus.done  <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            bus.memAddr <= bus.addr;
            bus.busy    <= 1'b1;
            if (bus.isStore) begin
              state        <= ST_WR;
              bus.memWe    <= 1'b1;
              bus.memWdata <= bus.storeData;
            end else begin
              state     <= ST_RD_REQ;
              bus.memRe <= 1'b1;
            end
          end else begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end
        end
        ST_WR: begin
          state    <= ST_DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        ST_RD_REQ: begin
          state    <= ST_RD_WAIT;
          wait_cnt <= 3'd0;
        end
        ST_RD_WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            state        <= ST_DONE;
            wait_cnt     <= 3'd0;
            bus.loadData <= bus.memRdata;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= 3'd0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance with 1-cycle memory latency
// and one with 3-cycle latency, each backed by a small behavioural RAM.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  load_store_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus1 ();
  load_store_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus3 ();
  lsu_dbg_t dbg1;
  lsu_dbg_t dbg3;

  load_store_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .dbg(dbg1)
  );
  load_store_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3), .dbg(dbg3)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memories ----------------
  // Preloaded on reset so the test words exist without a second writer.
  logic [15:0] mem1 [0:255];
  logic [15:0] mem3 [0:255];
  logic [15:0] rd1;
  logic [15:0] p0, p1, p2;

  always @(posedge clk) begin
    if (reset) begin
      mem1[8'h40] <= 16'hBEEF;
    end else if (bus1.memWe) begin
      mem1[bus1.memAddr[7:0]] <= bus1.memWdata;
    end
    if (bus1.memRe) rd1 <= mem1[bus1.memAddr[7:0]];
  end
  assign bus1.memRdata = rd1;

  always @(posedge clk) begin
    if (reset) begin
      mem3[8'h40] <= 16'hA5A5;
    end else if (bus3.memWe) begin
      mem3[bus3.memAddr[7:0]] <= bus3.memWdata;
    end
    p0 <= bus3.memRe ? mem3[bus3.memAddr[7:0]] : 16'h0000;
    p1 <= p0;
    p2 <= p1;
  end
  assign bus3.memRdata = p2;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic s, input logic st, input logic [15:0] a, input logic [15:0] d);
    bus1.start = s; bus1.isStore = st; bus1.addr = a; bus1.storeData = d;
  endtask

  task automatic drive3(input logic s, input logic st, input logic [15:0] a, input logic [15:0] d);
    bus3.start = s; bus3.isStore = st; bus3.addr = a; bus3.storeData = d;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet1(input string tag);
    chk({tag, ".memRe"}, 32'(bus1.memRe), 32'h0);
    chk({tag, ".memWe"}, 32'(bus1.memWe), 32'h0);
    chk({tag, ".busy"},  32'(bus1.busy),  32'h0);
    chk({tag, ".done"},  32'(bus1.done),  32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive1(1'b0, 1'b0, 16'h0, 16'h0);
    drive3(1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk_quiet1("rst");
    chk("rst.memAddr",  32'(bus1.memAddr),  32'h0);
    chk("rst.memWdata", 32'(bus1.memWdata), 32'h0);
    chk("rst.loadData", 32'(bus1.loadData), 32'h0);
    chk("rst.state",    32'(dbg1.state),    32'(ST_IDLE));
    chk("rst.wait",     32'(dbg1.wait_cnt), 32'h0);
    chk("rst3.loadData", 32'(bus3.loadData), 32'h0);
    chk("rst3.busy",     32'(bus3.busy),     32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_quiet1("idle");
    end

    // Load 0x0040 with 1-cycle memory
    drive1(1'b1, 1'b0, 16'h0040, 16'h0);
    step();
    drive1(1'b0, 1'b0, 16'h0, 16'h0);
    chk("ld.c1.memRe",   32'(bus1.memRe),   32'h1);
    chk("ld.c1.memWe",   32'(bus1.memWe),   32'h0);
    chk("ld.c1.memAddr", 32'(bus1.memAddr), 32'h0040);
    chk("ld.c1.busy",    32'(bus1.busy),    32'h1);
    chk("ld.c1.state",   32'(dbg1.state),   32'(ST_RD_REQ));
    step();
    chk("ld.c2.memRe", 32'(bus1.memRe), 32'h0);
    chk("ld.c2.busy",  32'(bus1.busy),  32'h1);
    chk("ld.c2.done",  32'(bus1.done),  32'h0);
    chk("ld.c2.state", 32'(dbg1.state), 32'(ST_RD_WAIT));
    step();
    chk("ld.c3.done",     32'(bus1.done),     32'h1);
    chk("ld.c3.busy",     32'(bus1.busy),     32'h0);
    chk("ld.c3.loadData", 32'(bus1.loadData), 32'hBEEF);
    step();
    chk("ld.c4.done",    32'(bus1.done),    32'h0);
    chk("ld.c4.state",   32'(dbg1.state),   32'(ST_IDLE));
    chk("ld.c4.memAddr", 32'(bus1.memAddr), 32'h0040);

    // Store 0x1234 to 0x0010, then back-to-back load from the DONE cycle
    drive1(1'b1, 1'b1, 16'h0010, 16'h1234);
    step();
    drive1(1'b0, 1'b0, 16'h0, 16'h0);
    chk("st.c1.memWe",    32'(bus1.memWe),    32'h1);
    chk("st.c1.memRe",    32'(bus1.memRe),    32'h0);
    chk("st.c1.memAddr",  32'(bus1.memAddr),  32'h0010);
    chk("st.c1.memWdata", 32'(bus1.memWdata), 32'h1234);
    chk("st.c1.busy",     32'(bus1.busy),     32'h1);
    step();
    chk("st.c2.done",     32'(bus1.done),     32'h1);
    chk("st.c2.memWe",    32'(bus1.memWe),    32'h0);
    chk("st.c2.busy",     32'(bus1.busy),     32'h0);
    chk("st.c2.loadData", 32'(bus1.loadData), 32'hBEEF);
    drive1(1'b1, 1'b0, 16'h0010, 16'h0);
    step();
    drive1(1'b0, 1'b0, 16'h0, 16'h0);
    chk("b2b.c1.memRe",    32'(bus1.memRe),    32'h1);
    chk("b2b.c1.memAddr",  32'(bus1.memAddr),  32'h0010);
    chk("b2b.c1.memWdata", 32'(bus1.memWdata), 32'h1234);
    chk("b2b.c1.done",     32'(bus1.done),     32'h0);
    step();
    chk("b2b.c2.done", 32'(bus1.done), 32'h0);
    step();
    chk("b2b.c3.done",     32'(bus1.done),     32'h1);
    chk("b2b.c3.loadData", 32'(bus1.loadData), 32'h1234);
    step();

    // start held while busy must not launch another access
    drive1(1'b1, 1'b0, 16'h0040, 16'h0);
    step();
    drive1(1'b1, 1'b1, 16'h0022, 16'hDEAD);
    chk("bsy.c1.memRe",   32'(bus1.memRe),   32'h1);
    chk("bsy.c1.memAddr", 32'(bus1.memAddr), 32'h0040);
    step();
    drive1(1'b0, 1'b0, 16'h0, 16'h0);
    chk("bsy.c2.memRe",   32'(bus1.memRe),   32'h0);
    chk("bsy.c2.memWe",   32'(bus1.memWe),   32'h0);
    chk("bsy.c2.memAddr", 32'(bus1.memAddr), 32'h0040);
    step();
    chk("bsy.c3.done",     32'(bus1.done),     32'h1);
    chk("bsy.c3.loadData", 32'(bus1.loadData), 32'hBEEF);
    step();
    chk_quiet1("bsy.c4");
    chk("bsy.c4.memWdata", 32'(bus1.memWdata), 32'h1234);
    chk("bsy.c4.state",    32'(dbg1.state),    32'(ST_IDLE));

    // 3-cycle memory latency: done in cycle 5
    drive3(1'b1, 1'b0, 16'h0040, 16'h0);
    step();
    drive3(1'b0, 1'b0, 16'h0, 16'h0);
    chk("l3.c1.memRe",   32'(bus3.memRe),   32'h1);
    chk("l3.c1.memAddr", 32'(bus3.memAddr), 32'h0040);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk("l3.wait.memRe", 32'(bus3.memRe), 32'h0);
      chk("l3.wait.busy",  32'(bus3.busy),  32'h1);
      chk("l3.wait.done",  32'(bus3.done),  32'h0);
      chk("l3.wait.state", 32'(dbg3.state), 32'(ST_RD_WAIT));
      chk("l3.wait.cnt",   32'(dbg3.wait_cnt), 32'(c - 2));
    end
    chk("l3.c4.loadData", 32'(bus3.loadData), 32'h0);
    step();
    chk("l3.c5.done",     32'(bus3.done),     32'h1);
    chk("l3.c5.busy",     32'(bus3.busy),     32'h0);
    chk("l3.c5.loadData", 32'(bus3.loadData), 32'hA5A5);
    step();
    chk("l3.c6.done", 32'(bus3.done), 32'h0);

    // Reset in the first RD_WAIT cycle aborts the load
    drive1(1'b1, 1'b0, 16'h0010, 16'h0);
    step();
    drive1(1'b0, 1'b0, 16'h0, 16'h0);
    chk("ab.c1.memRe", 32'(bus1.memRe), 32'h1);
    step();
    chk("ab.c2.state", 32'(dbg1.state), 32'(ST_RD_WAIT));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_quiet1("ab.c3");
    chk("ab.c3.loadData", 32'(bus1.loadData), 32'h0);
    chk("ab.c3.memAddr",  32'(bus1.memAddr),  32'h0);
    chk("ab.c3.memWdata", 32'(bus1.memWdata), 32'h0);
    chk("ab.c3.state",    32'(dbg1.state),    32'(ST_IDLE));
    chk("ab.c3.l3data",   32'(bus3.loadData), 32'h0);
    step();
    chk("ab.c4.done", 32'(bus1.done), 32'h0);
    drive1(1'b1, 1'b0, 16'h0040, 16'h0);
    step();
    drive1(1'b0, 1'b0, 16'h0, 16'h0);
    chk("rl.c1.memRe", 32'(bus1.memRe), 32'h1);
    step();
    chk("rl.c2.done", 32'(bus1.done), 32'h0);
    step();
    chk("rl.c3.done",     32'(bus1.done),     32'h1);
    chk("rl.c3.loadData", 32'(bus1.loadData), 32'hBEEF);
    step();

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
